block_map_reader: RTL and testbench
===================================

BLOCK_MAP_READER -- requirements
Module: block_map_reader

Interface
REQ-001 Parameter COLS, default 41: number of tile columns fetched per row (40 visible plus 1 partial for scroll).
REQ-002 Parameter MAP_COL_W, default 8: level-map column index width, so the map is 256 tiles wide.
REQ-003 Clk  in  1  sole clock; all logic on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse requesting a fetch of one tile row.
REQ-006 row  in  5  tile row (0..29); sampled on accepted start.
REQ-007 scroll_x  in  MAP_COL_W+4  camera pixel scroll; sampled on accepted start.
REQ-008 mem_rd  out  1  one-cycle read strobe to the block map store.
REQ-009 mem_addr  out  5+MAP_COL_W  read address {row, map_col}; valid while mem_rd=1.
REQ-010 mem_rvalid  in  1  read data valid, at least 1 cycle after mem_rd.
REQ-011 mem_rdata  in  4  block_id returned by the store.
REQ-012 out_valid  out  1  out_block_id/out_col are valid.
REQ-013 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-014 out_block_id  out  4  fetched block_id.
REQ-015 out_col  out  6  screen column index 0..COLS-1 of the fetched block.
REQ-016 busy  out  1  high from accepted start until row completion.
REQ-017 done  out  1  one-cycle pulse after the last column is accepted or skipped.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, PUSH.
REQ-019 IDLE: start=1 latches row, base_col = scroll_x >> 4, col = 0; next state ISSUE. busy asserts the following cycle.
REQ-020 start while busy: ignored, with no effect on the fetch in progress.
REQ-021 ISSUE: mem_rd=1 for exactly one cycle, mem_addr = {row, (base_col + col) mod 2^MAP_COL_W}; next state WAIT.
REQ-022 Map column wrap: the sum is truncated to MAP_COL_W bits, so base_col=255 and col=1 give map_col 0.
REQ-023 WAIT: at most one read outstanding. On mem_rvalid, capture mem_rdata; next state PUSH.
REQ-024 mem_rvalid while not in WAIT: ignored.
REQ-025 PUSH: out_valid=1; out_block_id and out_col are held stable until out_ready=1.
REQ-026 On handshake: if col = COLS-1, pulse done and return to IDLE; otherwise increment col and go to ISSUE.
REQ-027 Throughput: minimum 3 cycles per column (ISSUE, WAIT with rvalid, PUSH with ready).
REQ-028 out_valid is never high in IDLE, ISSUE or WAIT.
REQ-029 done and busy are never high in the same cycle as a newly accepted start.

Reset
REQ-030 Reset=1 forces state IDLE on the next edge, overriding start and any handshake.
REQ-031 Reset values: mem_rd=0, mem_addr=0, out_valid=0, out_block_id=0, out_col=0, busy=0, done=0, internal col/base_col/row=0.
REQ-032 Reset mid-fetch abandons the outstanding read; a late mem_rvalid after reset is ignored.

Configuration
REQ-033 Macro BLOCK_MAP_READER_SKIP_EMPTY_EN.
REQ-034 Defined: a captured block_id of 0 (empty/sky) skips PUSH with no out_valid. The FSM advances col, or finishes and pulses done, in the cycle after capture.
REQ-035 Undefined: every column, including block_id 0, is presented on the output.

Verification
REQ-036 Reset; row=3, scroll_x=0, start; mem returns addr[3:0]; out_ready=1 -> 41 outputs, col 0..40, mem_addr {3,0}..{3,40}, then one done pulse.
REQ-037 scroll_x=16*250 (4000), row=0 -> map_col sequence 250..255, then 0..34 (wrap).
REQ-038 out_ready low for 5 cycles at col 7 -> out_valid, out_block_id and out_col held constant, no new mem_rd until the handshake.
REQ-039 Reset asserted in WAIT at col 12; mem_rvalid the next cycle -> all outputs at reset values, no out_valid; a fresh start begins at col 0.
REQ-040 start pulsed again at col 5 -> ignored; the row completes with exactly 41 outputs.
REQ-041 With SKIP_EMPTY_EN, mem returns 0 for even columns -> only the 20 odd columns are output, and done pulses after col 40 is skipped.

Source files
------------

// File: rtl/block_map_reader.sv
// Block map reader: fetches one tile row of COLS block_ids from the level map, starting at the scrolled map column.
// Build option BLOCK_MAP_READER_SKIP_EMPTY_EN drops columns whose block_id is 0 instead of presenting them.
module block_map_reader #(
  parameter int COLS      = 41,
  parameter int MAP_COL_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [4:0]           row,
  input  logic [MAP_COL_W+3:0] scroll_x,
  output logic                 mem_rd,
  output logic [MAP_COL_W+4:0] mem_addr,
  input  logic                 mem_rvalid,
  input  logic [3:0]           mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_block_id,
  output logic [5:0]           out_col,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    PUSH  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  state_t               state_r, state_s;
  logic [5:0]           col_r, col_s;
  logic [MAP_COL_W-1:0] base_col_r, base_col_s;
  logic [4:0]           row_r, row_s;
  logic [MAP_COL_W-1:0] map_col_s;
  logic                 done_s;
  logic                 load_out_s;

  logic                 mem_rd_r;
  logic [MAP_COL_W+4:0] mem_addr_r;
  logic                 out_valid_r;
  logic [3:0]           out_block_id_r;
  logic [5:0]           out_col_r;
  logic                 busy_r;
  logic                 done_r;

  // Only whole tiles matter; the fine pixel offset is consumed by the renderer.
  logic unused_scroll_s;
  assign unused_scroll_s = ^scroll_x[3:0];

  // Next-state, column bookkeeping and output-load decisions.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    base_col_s = base_col_r;
    row_s      = row_r;
    done_s     = 1'b0;
    load_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        // A start colliding with the done pulse is dropped so done never overlaps an accepted start.
        if (start && !done_r) begin
          row_s      = row;
          base_col_s = scroll_x[MAP_COL_W+3:4];
          col_s      = 6'd0;
          state_s    = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
`ifdef BLOCK_MAP_READER_SKIP_EMPTY_EN
          if (mem_rdata == 4'd0) begin
            if (col_r == LAST_COL) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              col_s   = col_r + 6'd1;
              state_s = ISSUE;
            end
          end else begin
            load_out_s = 1'b1;
            state_s    = PUSH;
          end
`else
          load_out_s = 1'b1;
          state_s    = PUSH;
`endif
        end else begin
          state_s = WAIT;
        end
      end
      PUSH: begin
        if (out_ready) begin
          if (col_r == LAST_COL) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            col_s   = col_r + 6'd1;
            state_s = ISSUE;
          end
        end else begin
          state_s = PUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Map column wraps naturally by truncation to MAP_COL_W bits.
  assign map_col_s = base_col_s + MAP_COL_W'(col_s);

  // State and registered outputs, all derived from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r        <= IDLE;
      col_r          <= 6'd0;
      base_col_r     <= {MAP_COL_W{1'b0}};
      row_r          <= 5'd0;
      mem_rd_r       <= 1'b0;
      mem_addr_r     <= {(MAP_COL_W+5){1'b0}};
      out_valid_r    <= 1'b0;
      out_block_id_r <= 4'd0;
      out_col_r      <= 6'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      base_col_r  <= base_col_s;
      row_r       <= row_s;
      mem_rd_r    <= (state_s == ISSUE);
      out_valid_r <= (state_s == PUSH);
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
      if (state_s == ISSUE) begin
        mem_addr_r <= {row_s, map_col_s};
      end
      if (load_out_s) begin
        out_block_id_r <= mem_rdata;
        out_col_r      <= col_r;
      end
    end
  end

  assign mem_rd       = mem_rd_r;
  assign mem_addr     = mem_addr_r;
  assign out_valid    = out_valid_r;
  assign out_block_id = out_block_id_r;
  assign out_col      = out_col_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_block_map_reader.sv
// Directed self-checking bench for block_map_reader with a one-cycle-latency block map store model.
// Expectations adapt to BLOCK_MAP_READER_SKIP_EMPTY_EN when that macro is defined for the build.
module tb_block_map_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [4:0]  row;
  logic [11:0] scroll_x;
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [3:0]  mem_rdata = 4'd0;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_block_id;
  logic [5:0]  out_col;
  logic        busy;
  logic        done;

  logic        mem_auto;
  int          mem_mode;
  logic        force_rv;
  logic [3:0]  force_data;

  int tests = 0;
  int fails = 0;

  block_map_reader #(.COLS(41), .MAP_COL_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .row(row), .scroll_x(scroll_x),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_block_id(out_block_id),
    .out_col(out_col), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Store contents: mode 0 returns addr[3:0]; mode 1 returns 0 for even map columns.
  function automatic logic [3:0] data_fn(input logic [12:0] a, input int mode);
    if (mode == 1 && a[0] == 1'b0) return 4'd0;
    return a[3:0];
  endfunction

  function automatic bit shown(input logic [3:0] d);
`ifdef BLOCK_MAP_READER_SKIP_EMPTY_EN
    return d != 4'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Store model: answers each read strobe one cycle later, or returns a forced late response.
  always @(posedge Clk) begin
    mem_rvalid <= force_rv || (mem_auto && mem_rd);
    if (force_rv) mem_rdata <= force_data;
    else if (mem_auto && mem_rd) mem_rdata <= data_fn(mem_addr, mem_mode);
  end

  task automatic start_row(input logic [4:0] r, input logic [11:0] sx);
    @(negedge Clk);
    start = 1'b1; row = r; scroll_x = sx;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b1; row = 5'd7; scroll_x = 12'd100; out_ready = 1'b1;
    repeat (3) @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset_mem_rd: got %0h want 0", mem_rd); end
    tests++; if (mem_addr !== 13'd0) begin fails++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
    tests++; if (out_block_id !== 4'd0) begin fails++; $display("FAIL reset_block_id: got %0h want 0", out_block_id); end
    tests++; if (out_col !== 6'd0) begin fails++; $display("FAIL reset_out_col: got %0h want 0", out_col); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0h want 0", done); end
  endtask

  // Full-row fetch: checks every address, every output, done timing; optional stall and stray start.
  task automatic test_full_row(input string nm, input logic [4:0] r, input logic [11:0] sx,
                               input int mode, input int stall_col, input int spur_col);
    logic [7:0] base, mc;
    logic [3:0] ed;
    int n_issue, n_out, ecol, n_done, done_c, exp_n, exp_done_c, stalled;
    bit spurred;
    base = sx[11:4];
    n_issue = 0; n_out = 0; ecol = 0; n_done = 0; done_c = -1; stalled = 0; spurred = 1'b0;
    exp_n = 0; exp_done_c = 1;
    for (int i = 0; i < 41; i++) begin
      mc = base + 8'(i);
      if (shown(data_fn({r, mc}, mode))) begin exp_n++; exp_done_c += 3; end
      else exp_done_c += 2;
    end
    if (stall_col >= 0) exp_done_c += 5;
    mem_mode = mode; out_ready = 1'b1;
    start_row(r, sx);
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) begin
        tests++; if (busy !== 1'b1 || mem_rd !== 1'b1 || out_valid !== 1'b0) begin
          fails++; $display("FAIL %s_first_cycle: got busy=%0h rd=%0h vld=%0h want 1 1 0", nm, busy, mem_rd, out_valid);
        end
      end
      if (mem_rd) begin
        mc = base + 8'(n_issue);
        tests++; if (mem_addr !== {r, mc}) begin fails++; $display("FAIL %s_addr%0d: got %0h want %0h", nm, n_issue, mem_addr, {r, mc}); end
        n_issue++;
      end
      if (out_valid) begin
        while (ecol < 41 && !shown(data_fn({r, base + 8'(ecol)}, mode))) ecol++;
        mc = base + 8'(ecol);
        ed = data_fn({r, mc}, mode);
        tests++; if (out_col !== 6'(ecol)) begin fails++; $display("FAIL %s_out_col: got %0d want %0d", nm, out_col, ecol); end
        tests++; if (out_block_id !== ed) begin fails++; $display("FAIL %s_block_id%0d: got %0h want %0h", nm, ecol, out_block_id, ed); end
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL %s_rd_in_push: got %0h want 0", nm, mem_rd); end
        if (ecol == spur_col && !spurred) begin
          start = 1'b1; row = 5'd9; scroll_x = 12'd0; spurred = 1'b1;
        end else begin
          start = 1'b0;
        end
        if (ecol == stall_col && stalled < 5) begin
          out_ready = 1'b0; stalled++;
        end else begin
          out_ready = 1'b1; n_out++; ecol++;
        end
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (done_c < 0) done_c = c;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_at_done: got %0h want 0", nm, busy); end
      end
      @(negedge Clk);
    end
    start = 1'b0; out_ready = 1'b1;
    tests++; if (n_issue != 41) begin fails++; $display("FAIL %s_reads: got %0d want 41", nm, n_issue); end
    tests++; if (n_out != exp_n) begin fails++; $display("FAIL %s_outputs: got %0d want %0d", nm, n_out, exp_n); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL %s_done_count: got %0d want 1", nm, n_done); end
    tests++; if (done_c != exp_done_c) begin fails++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, done_c, exp_done_c); end
  endtask

  task automatic test_reset_mid_fetch();
    int n_issue, n_done;
    bit hit, seen_rd, seen_out;
    n_issue = 0; hit = 1'b0; n_done = 0; seen_rd = 1'b0; seen_out = 1'b0;
    mem_mode = 0; out_ready = 1'b1;
    start_row(5'd2, 12'd0);
    for (int c = 0; c < 200 && !hit; c++) begin
      if (mem_rd) begin
        if (n_issue == 12) begin mem_auto = 1'b0; hit = 1'b1; end
        n_issue++;
      end
      if (!hit) @(negedge Clk);
    end
    tests++; if (!hit) begin fails++; $display("FAIL rst_mid_reach_col12: got %0d reads want 13", n_issue); end
    @(negedge Clk);
    Reset = 1'b1; force_rv = 1'b1; force_data = 4'hF;
    @(negedge Clk);
    Reset = 1'b0; force_rv = 1'b0;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0) begin
      fails++; $display("FAIL rst_mid_ctrl: got vld=%0h busy=%0h done=%0h rd=%0h want 0 0 0 0", out_valid, busy, done, mem_rd);
    end
    tests++; if (mem_addr !== 13'd0 || out_col !== 6'd0 || out_block_id !== 4'd0) begin
      fails++; $display("FAIL rst_mid_data: got addr=%0h col=%0h id=%0h want 0 0 0", mem_addr, out_col, out_block_id);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
        fails++; $display("FAIL rst_mid_late_rvalid: got vld=%0h busy=%0h rd=%0h want 0 0 0", out_valid, busy, mem_rd);
      end
    end
    mem_auto = 1'b1;
    start_row(5'd2, 12'd0);
    for (int c = 0; c < 200 && n_done == 0; c++) begin
      if (mem_rd && !seen_rd) begin
        seen_rd = 1'b1;
        tests++; if (mem_addr !== {5'd2, 8'd0}) begin fails++; $display("FAIL rst_mid_restart_addr: got %0h want %0h", mem_addr, {5'd2, 8'd0}); end
      end
      if (out_valid && !seen_out) begin
        seen_out = 1'b1;
        tests++; if (out_col !== 6'd0) begin fails++; $display("FAIL rst_mid_restart_col: got %0d want 0", out_col); end
      end
      if (done) n_done++;
      @(negedge Clk);
    end
    tests++; if (n_done != 1) begin fails++; $display("FAIL rst_mid_restart_done: got %0d want 1", n_done); end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; row = 5'd0; scroll_x = 12'd0; out_ready = 1'b1;
    mem_auto = 1'b1; mem_mode = 0; force_rv = 1'b0; force_data = 4'd0;
    test_reset();
    test_full_row("basic", 5'd3, 12'd0, 0, -1, -1);
    test_full_row("wrap", 5'd0, 12'd4000, 0, -1, -1);
    test_full_row("stall", 5'd1, 12'd0, 0, 7, -1);
    test_full_row("stray_start", 5'd4, 12'd32, 0, -1, 5);
    test_full_row("empty_even", 5'd0, 12'd0, 1, -1, -1);
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
